// File: rtl/dac_scaler.sv
// -----------------------------------------------------------------------------
// dac_scaler
//
// Transmit-side sample scaler. 12-bit unsigned codes arrive on a valid/ready
// handshake and are buffered in a small FIFO. A free-running rate counter
// produces one update tick every DIV clocks. On each tick the head code is
// popped and run through a three-stage pipeline: clamp to CODE_MAX, scale by
// 0.8 (rounded half-up), negate into a signed 14-bit DAC word. A tick that
// finds the FIFO empty sends an underrun token down the same pipeline. That
// token raises dac_upd and underrun together, leaves dac_dat/sat unchanged and
// bumps a saturating underrun counter.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_dat[11:0]  unsigned sample code
//   in_valid      in_dat valid
//   in_ready      registered: FIFO can take a word this cycle
//   dac_dat[13:0] signed DAC word, changes only on dac_upd
//   dac_upd       one-cycle strobe per update tick (3 cycles after the tick)
//   sat[1:0]      00 normal, 10 code was clamped high
//   underrun      one-cycle pulse: this update found the FIFO empty
//   underrun_cnt  saturating count of underruns
// -----------------------------------------------------------------------------
module dac_scaler #(
   parameter int unsigned DIV        = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CODE_MAX   = 3981
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] in_dat,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [13:0] dac_dat,
   output logic        dac_upd,
   output logic [1:0]  sat,
   output logic        underrun,
   output logic [15:0] underrun_cnt
);

   localparam int unsigned CW = $clog2(DIV);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [11:0]   CODE_LIM = 12'(CODE_MAX);
   localparam logic [AW:0]   DEPTH_V  = (AW + 1)'(FIFO_DEPTH);

   // rate counter and FIFO bookkeeping
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          in_ready_q, in_ready_d;
   logic [11:0]   fifo_mem [FIFO_DEPTH];

   // pipeline stage 1: clamp
   logic          s1_vld_q, s1_vld_d;
   logic          s1_unr_q, s1_unr_d;
   logic [11:0]   s1_code_q, s1_code_d;
   logic [1:0]    s1_sat_q, s1_sat_d;

   // pipeline stage 2: scale
   logic          s2_vld_q, s2_vld_d;
   logic          s2_unr_q, s2_unr_d;
   logic [11:0]   s2_val_q, s2_val_d;
   logic [1:0]    s2_sat_q, s2_sat_d;

   // stage 3: output registers
   logic [13:0]   dac_dat_q, dac_dat_d;
   logic          dac_upd_q, dac_upd_d;
   logic [1:0]    sat_q, sat_d;
   logic          underrun_q, underrun_d;
   logic [15:0]   underrun_cnt_q, underrun_cnt_d;

   logic          tick, push, pop;
   logic [11:0]   fifo_head;
   logic [25:0]   s2_prod;

   always_comb begin
      // NOTE: every signal written here gets a default first so no path can
      // leave it unassigned and infer a latch.
      tick      = (cnt_q == CNT_LAST);
      push      = in_valid && in_ready_q;
      pop       = tick && (count_q != '0);
      fifo_head = fifo_mem[rd_ptr_q];

      cnt_d    = tick ? '0 : cnt_q + CW'(1);
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;

      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
      in_ready_d = (count_d < DEPTH_V);

      // S1: a tick on an empty FIFO becomes an underrun token; a same-cycle
      // push is not bypassed to it and waits for the next tick.
      s1_vld_d  = tick;
      s1_unr_d  = tick && (count_q == '0);
      s1_code_d = s1_code_q;
      s1_sat_d  = s1_sat_q;
      if (pop) begin
         s1_code_d = (fifo_head > CODE_LIM) ? CODE_LIM : fifo_head;
         s1_sat_d  = (fifo_head > CODE_LIM) ? 2'b10 : 2'b00;
      end

      // S2: 13107/16384 ~= 0.8, +8192 rounds half-up; CODE_LIM keeps the
      // product inside 26 bits.
      s2_prod  = 26'(s1_code_q) * 26'd13107 + 26'd8192;
      s2_vld_d = s1_vld_q;
      s2_unr_d = s1_unr_q;
      s2_val_d = 12'(s2_prod >> 14);
      s2_sat_d = s1_sat_q;

      // S3: underrun tokens strobe but leave dac_dat/sat untouched.
      dac_upd_d  = s2_vld_q;
      underrun_d = s2_vld_q && s2_unr_q;
      dac_dat_d  = dac_dat_q;
      sat_d      = sat_q;
      if (s2_vld_q && !s2_unr_q) begin
         dac_dat_d = 14'd0 - {2'b00, s2_val_q};
         sat_d     = s2_sat_q;
      end
      underrun_cnt_d = underrun_cnt_q;
      if (underrun_d && (underrun_cnt_q != 16'hFFFF)) begin
         underrun_cnt_d = underrun_cnt_q + 16'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours regardless of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q          <= '0;
         rd_ptr_q       <= '0;
         wr_ptr_q       <= '0;
         count_q        <= '0;
         in_ready_q     <= 1'b0;
         s1_vld_q       <= 1'b0;
         s1_unr_q       <= 1'b0;
         s1_code_q      <= '0;
         s1_sat_q       <= '0;
         s2_vld_q       <= 1'b0;
         s2_unr_q       <= 1'b0;
         s2_val_q       <= '0;
         s2_sat_q       <= '0;
         dac_dat_q      <= '0;
         dac_upd_q      <= 1'b0;
         sat_q          <= '0;
         underrun_q     <= 1'b0;
         underrun_cnt_q <= '0;
      end else begin
         cnt_q          <= cnt_d;
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         count_q        <= count_d;
         in_ready_q     <= in_ready_d;
         s1_vld_q       <= s1_vld_d;
         s1_unr_q       <= s1_unr_d;
         s1_code_q      <= s1_code_d;
         s1_sat_q       <= s1_sat_d;
         s2_vld_q       <= s2_vld_d;
         s2_unr_q       <= s2_unr_d;
         s2_val_q       <= s2_val_d;
         s2_sat_q       <= s2_sat_d;
         dac_dat_q      <= dac_dat_d;
         dac_upd_q      <= dac_upd_d;
         sat_q          <= sat_d;
         underrun_q     <= underrun_d;
         underrun_cnt_q <= underrun_cnt_d;
      end
   end

   // NOTE: FIFO storage has no reset; emptiness is carried by the pointers
   // and count, so stale entries are never read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= in_dat;
      end
   end

   assign in_ready     = in_ready_q;
   assign dac_dat      = dac_dat_q;
   assign dac_upd      = dac_upd_q;
   assign sat          = sat_q;
   assign underrun     = underrun_q;
   assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_dac_scaler.sv
// -----------------------------------------------------------------------------
// tb_dac_scaler
//
// Bench for dac_scaler. A transaction-level model (queue of codes, list of
// scheduled updates) predicts every output each cycle; the compare runs on
// the falling edge. Directed scenarios add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_dac_scaler;

   localparam int DIV      = 4;
   localparam int DEPTH    = 4;
   localparam int CODE_MAX = 3981;

   logic        clk;
   logic        rst_n;
   logic [11:0] in_dat;
   logic        in_valid;
   logic        in_ready;
   logic [13:0] dac_dat;
   logic        dac_upd;
   logic [1:0]  sat;
   logic        underrun;
   logic [15:0] underrun_cnt;

   dac_scaler #(.DIV(DIV), .FIFO_DEPTH(DEPTH), .CODE_MAX(CODE_MAX)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_dat       (in_dat),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .dac_dat      (dac_dat),
      .dac_upd      (dac_upd),
      .sat          (sat),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   typedef struct {
      int due;
      bit unr;
      int dat;
      int sat;
   } upd_t;

   upd_t ev[$];
   int   m_q[$];
   int   m_cnt, m_edge, m_unr_total;
   bit   m_ready, exp_upd, exp_unr;
   int   exp_dat, exp_sat;
   bit   preset_on;
   int   preset_at;

   function automatic int scale(input int code);
      int c;
      c = (code > CODE_MAX) ? CODE_MAX : code;
      return -((c * 13107 + 8192) / 16384);
   endfunction

   function automatic int exp_ucnt();
      int v;
      v = preset_on ? 65534 + (m_unr_total - preset_at) : m_unr_total;
      return (v > 65535) ? 65535 : v;
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_q.delete();
            ev.delete();
            m_cnt = 0; m_edge = 0; m_unr_total = 0; m_ready = 0;
            exp_upd = 0; exp_unr = 0; exp_dat = 0; exp_sat = 0;
         end else begin
            bit  push, tick;
            int  code;
            upd_t e;
            push = in_valid && m_ready;
            tick = (m_cnt == DIV - 1);
            m_edge++;
            exp_upd = 0;
            exp_unr = 0;
            if (ev.size() > 0 && ev[0].due == m_edge) begin
               e = ev.pop_front();
               exp_upd = 1;
               if (e.unr) begin
                  exp_unr = 1;
                  m_unr_total++;
               end else begin
                  exp_dat = e.dat;
                  exp_sat = e.sat;
               end
            end
            if (tick) begin
               if (m_q.size() > 0) begin
                  code = m_q.pop_front();
                  ev.push_back('{due: m_edge + 2, unr: 1'b0, dat: scale(code),
                                 sat: (code > CODE_MAX) ? 2 : 0});
               end else begin
                  ev.push_back('{due: m_edge + 2, unr: 1'b1, dat: 0, sat: 0});
               end
            end
            if (push) m_q.push_back(int'(in_dat));
            m_ready = (m_q.size() < DEPTH);
            m_cnt   = (m_cnt + 1) % DIV;
         end
      end
   end

   // ------------------------------------------------------- compare + log
   int obs_unr[$];
   int obs_dat[$];
   int obs_sat[$];

   function automatic int n_unr();
      int n = 0;
      foreach (obs_unr[i]) n += obs_unr[i];
      return n;
   endfunction

   task automatic clear_obs();
      obs_unr.delete(); obs_dat.delete(); obs_sat.delete();
   endtask

   task automatic step();
      @(negedge clk);
      if (rst_n) begin
         check("dac_upd",      dac_upd,          exp_upd);
         check("underrun",     underrun,         exp_unr);
         check("in_ready",     in_ready,         m_ready);
         check("underrun_cnt", underrun_cnt,     exp_ucnt());
         check("dac_dat",      $signed(dac_dat), exp_dat);
         check("sat",          sat,              exp_sat);
         if (dac_upd) begin
            obs_unr.push_back(int'(underrun));
            obs_dat.push_back(int'($signed(dac_dat)));
            obs_sat.push_back(int'(sat));
         end
      end else begin
         check("rst_dac_upd",  dac_upd,      0);
         check("rst_dac_dat",  dac_dat,      0);
         check("rst_in_ready", in_ready,     0);
         check("rst_ucnt",     underrun_cnt, 0);
      end
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      preset_on = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      clear_obs();
   endtask

   task automatic send(input int v);
      bit acc = 0;
      in_valid = 1'b1;
      in_dat   = 12'(v);
      for (int k = 0; k < 100 && !acc; k++) begin
         bit rdy;
         rdy = in_ready;
         step();
         acc = rdy;
      end
      in_valid = 1'b0;
      check("send_accepted", acc, 1);
   endtask

   task automatic wait_updates(input int n, input int budget, input string name);
      for (int k = 0; k < budget && obs_unr.size() < n; k++) step();
      check(name, obs_unr.size() >= n, 1);
   endtask

   function automatic int pick_code();
      case ($urandom_range(7))
         0:       return 0;
         1:       return 1;
         2:       return CODE_MAX - 1;
         3:       return CODE_MAX;
         4:       return CODE_MAX + 1;
         5:       return 4095;
         default: return int'($urandom_range(4095));
      endcase
   endfunction

   // ------------------------------------------------------------ stimulus
   initial begin
      int good_dat[$];
      int good_sat[$];
      int n;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_dat   = '0;
      preset_on = 1'b0;
      preset_at = 0;
      step();
      do_reset();

      // single code 1000 before the first tick, then ten underruns
      send(1000);
      wait_updates(1, 40, "s1_first_update");
      if (obs_unr.size() >= 1) begin
         check("s1_unr", obs_unr[0], 0);
         check("s1_dat", obs_dat[0], -800);
         check("s1_sat", obs_sat[0], 0);
      end
      for (int k = 0; k < 200 && n_unr() < 10; k++) step();
      check("s4_ucnt_10", underrun_cnt, 10);
      check("s4_dat_held", $signed(dac_dat), -800);
      dut.underrun_cnt_q = 16'hFFFE;
      preset_at = m_unr_total;
      preset_on = 1'b1;
      for (int k = 0; k < 200 && n_unr() < 13; k++) step();
      check("s4_ucnt_sat", underrun_cnt, 16'hFFFF);
      repeat (2 * DIV) step();

      // clamp boundary and order
      do_reset();
      send(4095); send(3981); send(0); send(5);
      for (int k = 0; k < 80; k++) begin
         step();
         n = 0;
         foreach (obs_unr[i]) if (!obs_unr[i]) n++;
         if (n >= 4) break;
      end
      good_dat.delete(); good_sat.delete();
      foreach (obs_unr[i]) if (!obs_unr[i]) begin
         good_dat.push_back(obs_dat[i]);
         good_sat.push_back(obs_sat[i]);
      end
      check("s2_count", good_dat.size(), 4);
      if (good_dat.size() >= 4) begin
         check("s2_dat0", good_dat[0], -3185); check("s2_sat0", good_sat[0], 2);
         check("s2_dat1", good_dat[1], -3185); check("s2_sat1", good_sat[1], 0);
         check("s2_dat2", good_dat[2], 0);     check("s2_sat2", good_sat[2], 0);
         check("s2_dat3", good_dat[3], -4);    check("s2_sat3", good_sat[3], 0);
      end

      // back-to-back 1..6 against a filling FIFO
      do_reset();
      for (int v = 1; v <= 6; v++) send(v);
      for (int k = 0; k < 120; k++) begin
         step();
         n = 0;
         foreach (obs_unr[i]) if (!obs_unr[i]) n++;
         if (n >= 6) break;
      end
      good_dat.delete();
      foreach (obs_unr[i]) if (!obs_unr[i]) good_dat.push_back(obs_dat[i]);
      check("s3_count", good_dat.size(), 6);
      if (good_dat.size() >= 6) begin
         check("s3_dat0", good_dat[0], -1);
         check("s3_dat1", good_dat[1], -2);
         check("s3_dat2", good_dat[2], -2);
         check("s3_dat3", good_dat[3], -3);
         check("s3_dat4", good_dat[4], -4);
         check("s3_dat5", good_dat[5], -5);
      end

      // push exactly in the tick cycle of an empty FIFO
      do_reset();
      for (int k = 0; k < 20 && m_cnt != DIV - 1; k++) step();
      in_valid = 1'b1;
      in_dat   = 12'd2000;
      step();
      in_valid = 1'b0;
      wait_updates(2, 40, "s5_two_updates");
      if (obs_unr.size() >= 2) begin
         check("s5_unr0", obs_unr[0], 1);
         check("s5_unr1", obs_unr[1], 0);
         check("s5_dat1", obs_dat[1], -1600);
      end

      // asynchronous reset with FIFO full and pipeline busy
      do_reset();
      send(100); send(200); send(300); send(400); send(500);
      in_valid = 1'b1;
      in_dat   = 12'd600;
      repeat (3) step();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("s6_async_dac_dat",  dac_dat,      0);
      check("s6_async_dac_upd",  dac_upd,      0);
      check("s6_async_sat",      sat,          0);
      check("s6_async_underrun", underrun,     0);
      check("s6_async_ucnt",     underrun_cnt, 0);
      check("s6_async_in_ready", in_ready,     0);
      in_valid  = 1'b0;
      preset_on = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      clear_obs();
      n = 0;
      for (int k = 0; k < 40 && obs_unr.size() == 0; k++) begin
         step();
         n++;
      end
      check("s6_first_upd_cycle", n, DIV + 2);
      if (obs_unr.size() >= 1) check("s6_first_is_underrun", obs_unr[0], 1);

      // randomized traffic at several input rates, one reset in between
      do_reset();
      foreach (good_sat[i]) good_sat[i] = 0;
      for (int seg = 0; seg < 3; seg++) begin
         int p;
         p = (seg == 0) ? 25 : (seg == 1) ? 60 : 95;
         for (int k = 0; k < 800; k++) begin
            if (seg == 1 && k == 400) do_reset();
            in_valid = ($urandom_range(99) < p);
            in_dat   = 12'(pick_code());
            step();
         end
      end
      in_valid = 1'b0;
      repeat (4 * DIV) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
